// File: rtl/dcache_s1_req_pipe.sv
// Stage-1 request front end of the non-blocking data cache: arbitrates NREQ
// requestors onto the single array read port and captures the winner into s1.
module dcache_s1_req_pipe #(
    parameter int NREQ   = 5,
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 9,
    parameter int WAYS   = 4,
    parameter int IDX_LO = 6,
    parameter int IDX_W  = 6,
    parameter int RR     = 0,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          in_valid,
    output logic [NREQ-1:0]          in_ready,
    input  logic [NREQ*ADDR_W-1:0]   in_addr,
    input  logic [NREQ*TAG_W-1:0]    in_tag,
    input  logic [NREQ*5-1:0]        in_cmd,
    input  logic [NREQ*3-1:0]        in_typ,
    input  logic [NREQ-1:0]          in_kill,
    input  logic [NREQ-1:0]          in_phys,
    input  logic [NREQ*DATA_W-1:0]   in_data,
    input  logic [NREQ*WAYS-1:0]     in_way_en,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [IDX_W-1:0]         rd_idx,
    output logic [WAYS-1:0]          rd_way_en,
    input  logic                     s1_stall,
    input  logic                     s1_flush,
    output logic                     s1_valid,
    output logic [SRC_W-1:0]         s1_src,
    output logic [ADDR_W-1:0]        s1_addr,
    output logic [TAG_W-1:0]         s1_tag,
    output logic [4:0]               s1_cmd,
    output logic [2:0]               s1_typ,
    output logic                     s1_kill,
    output logic                     s1_phys,
    output logic [DATA_W-1:0]        s1_data,
    output logic [WAYS-1:0]          s1_way_en
);

    localparam logic [SRC_W-1:0] PTR_RST = SRC_W'(NREQ - 1);

    if (IDX_LO + IDX_W > ADDR_W) begin : g_idx_check
        $error("dcache_s1_req_pipe: set index slice exceeds ADDR_W");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
        $error("dcache_s1_req_pipe: NREQ must be 2..8");
    end

    // Pointer increment modulo NREQ; the only arithmetic in the block.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] base, input int step);
        int sum;
        int wrapped;
        sum = int'(base) + step;
        if (sum >= NREQ) begin
            wrapped = sum - NREQ;
        end else begin
            wrapped = sum;
        end
        return SRC_W'(wrapped);
    endfunction

    logic [ADDR_W-1:0] addr_a  [NREQ];
    logic [TAG_W-1:0]  tag_a   [NREQ];
    logic [4:0]        cmd_a   [NREQ];
    logic [2:0]        typ_a   [NREQ];
    logic [DATA_W-1:0] data_a  [NREQ];
    logic [WAYS-1:0]   way_a   [NREQ];

    logic [SRC_W-1:0]  ptr_r;
    logic [SRC_W-1:0]  win_s;
    logic [SRC_W-1:0]  cand_s;
    logic              found_s;
    logic              grant_ok_s;
    logic              accept_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_chan
        assign addr_a[g]   = in_addr[g*ADDR_W +: ADDR_W];
        assign tag_a[g]    = in_tag[g*TAG_W +: TAG_W];
        assign cmd_a[g]    = in_cmd[g*5 +: 5];
        assign typ_a[g]    = in_typ[g*3 +: 3];
        assign data_a[g]   = in_data[g*DATA_W +: DATA_W];
        assign way_a[g]    = in_way_en[g*WAYS +: WAYS];
        assign in_ready[g] = grant_ok_s && (win_s == SRC_W'(g));
    end

    // Winner search: index order for fixed priority, from ptr+1 with wrap for round-robin.
    always_comb begin
        win_s   = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (RR != 0) begin
                cand_s = wrap_inc(ptr_r, k + 1);
            end else begin
                cand_s = SRC_W'(k);
            end
            if (!found_s && in_valid[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign rd_valid   = found_s & ~s1_stall & ~reset;
    assign grant_ok_s = rd_valid & rd_ready;
    assign accept_s   = grant_ok_s;
    assign rd_idx     = addr_a[win_s][IDX_LO +: IDX_W];
    assign rd_way_en  = way_a[win_s];

    // s1 pipeline register and round-robin pointer; a flush only kills the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_src    <= '0;
            s1_addr   <= '0;
            s1_tag    <= '0;
            s1_cmd    <= 5'd0;
            s1_typ    <= 3'd0;
            s1_kill   <= 1'b0;
            s1_phys   <= 1'b1;
            s1_data   <= '0;
            s1_way_en <= '0;
            ptr_r     <= PTR_RST;
        end else if (accept_s) begin
            s1_valid  <= 1'b1;
            s1_src    <= win_s;
            s1_addr   <= addr_a[win_s];
            s1_tag    <= tag_a[win_s];
            s1_cmd    <= cmd_a[win_s];
            s1_typ    <= typ_a[win_s];
            s1_kill   <= in_kill[win_s];
            s1_phys   <= in_phys[win_s];
            s1_data   <= data_a[win_s];
            s1_way_en <= way_a[win_s];
            ptr_r     <= win_s;
        end else if (s1_stall && !s1_flush) begin
            s1_valid  <= s1_valid;
        end else begin
            s1_valid  <= 1'b0;
        end
    end

endmodule
